// File: rtl/lk_pkg.sv
// Shared types and fixed-point helpers for the Lucas-Kanade iteration controller.
package lk_pkg;

  localparam int LK_D_W    = 40;
  localparam int LK_FRAC   = 32;
  localparam int LK_WIDE_W = 97;

  typedef enum logic [1:0] {
    LK_CONV  = 2'd0,
    LK_MAXIT = 2'd1,
    LK_LOST  = 2'd2,
    LK_SING  = 2'd3
  } lk_status_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_MUL,
    ST_ACC,
    ST_CHK,
    ST_DONE
  } lk_state_t;

  function automatic logic signed [LK_D_W-1:0] lk_sat(input logic signed [LK_WIDE_W-1:0] v);
    logic [LK_WIDE_W-LK_D_W:0] hi;
    hi = v[LK_WIDE_W-1:LK_D_W-1];
    if ((&hi) || !(|hi)) return v[LK_D_W-1:0];
    else if (v[LK_WIDE_W-1]) return {1'b1, {(LK_D_W-1){1'b0}}};
    else return {1'b0, {(LK_D_W-1){1'b1}}};
  endfunction

  // s is sum[D_W-1:FRAC-1]: integer part plus the half-pixel bit, round half up
  function automatic logic signed [LK_D_W-LK_FRAC:0] lk_rnd(input logic [LK_D_W-LK_FRAC:0] s);
    return $signed({s[LK_D_W-LK_FRAC], s[LK_D_W-LK_FRAC:1]})
         + $signed({{(LK_D_W-LK_FRAC){1'b0}}, s[0]});
  endfunction

endpackage

// File: rtl/lk_solve2x2_pipe.sv
// Two-stage d = G^-1 * b: products registered, then summed, shifted into Q.FRAC and saturated.
module lk_solve2x2_pipe
  import lk_pkg::*;
#(
  parameter int PROD_SHIFT = 28
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [63:0]       g11,
  input  logic signed [63:0]       g12,
  input  logic signed [63:0]       g22,
  input  logic signed [31:0]       bx,
  input  logic signed [31:0]       by,
  output logic                     out_valid,
  output logic signed [LK_D_W-1:0] dx,
  output logic signed [LK_D_W-1:0] dy
);

  logic signed [95:0]          p11, p12x, p12y, p22;
  logic                        v1;
  logic signed [LK_WIDE_W-1:0] acc_x, acc_y;

  always_comb begin
    acc_x = (LK_WIDE_W'(p11) + LK_WIDE_W'(p12y)) >>> PROD_SHIFT;
    acc_y = (LK_WIDE_W'(p12x) + LK_WIDE_W'(p22)) >>> PROD_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      p11       <= '0;
      p12x      <= '0;
      p12y      <= '0;
      p22       <= '0;
      dx        <= '0;
      dy        <= '0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
      if (in_valid) begin
        p11  <= g11 * bx;
        p12x <= g12 * bx;
        p12y <= g12 * by;
        p22  <= g22 * by;
      end
      if (v1) begin
        dx <= lk_sat(acc_x);
        dy <= lk_sat(acc_y);
      end
    end
  end

endmodule

// File: rtl/lk_iter_ctrl.sv
// Per-feature iterative Lucas-Kanade refinement: fetch b, solve d = G^-1 b, accumulate, test for exit.
//  state | meaning
//  IDLE  | waiting for start; results of the last feature held
//  REQ   | b_req high at the rounded current position, waiting for b_valid
//  MUL   | two cycles in the solve pipeline
//  ACC   | sum += d, iter_cnt += 1
//  CHK   | exit test: converged, lost, iteration cap, else next request
//  DONE  | one-cycle done pulse, status valid
module lk_iter_ctrl
  import lk_pkg::*;
#(
  parameter int COL        = 30,
  parameter int ROW        = 20,
  parameter int COLBITS    = 6,
  parameter int ROWBITS    = 5,
  parameter int D_W        = LK_D_W,
  parameter int FRAC       = LK_FRAC,
  parameter int PROD_SHIFT = 28,
  parameter int MAX_ITER   = 8,
  parameter logic signed [D_W-1:0] EPS = 40'sh00_0100_0000,
  localparam int ITW       = $clog2(MAX_ITER + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [COLBITS-1:0]        x,
  input  logic [ROWBITS-1:0]        y,
  input  logic signed [63:0]        ginv_11,
  input  logic signed [63:0]        ginv_12,
  input  logic signed [63:0]        ginv_22,
  input  logic                      valid_det,
  output logic                      b_req,
  output logic [COLBITS-1:0]        b_x,
  output logic [ROWBITS-1:0]        b_y,
  input  logic                      b_valid,
  input  logic signed [31:0]        bx,
  input  logic signed [31:0]        by,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                status,
  output logic [ITW-1:0]            iter_cnt,
  output logic signed [D_W-1:0]     sum_dx,
  output logic signed [D_W-1:0]     sum_dy
);

  localparam int PW = D_W - FRAC + COLBITS + ROWBITS + 2;

  lk_state_t                state_q, state_n;
  lk_status_t               status_q, st_val;
  logic [COLBITS-1:0]       x_q;
  logic [ROWBITS-1:0]       y_q;
  logic signed [63:0]       g11_q, g12_q, g22_q;
  logic signed [31:0]       bx_q, by_q;
  logic                     mul_ph, accept, cap, set_st;
  logic                     d_valid, conv, lost;
  logic signed [D_W-1:0]    dx, dy;
  logic signed [D_W-FRAC:0] rnd_x, rnd_y;
  logic signed [PW-1:0]     pos_x, pos_y;

  lk_solve2x2_pipe #(.PROD_SHIFT(PROD_SHIFT)) u_solve (
    .clk      (clk),
    .reset    (reset),
    .in_valid ((state_q == ST_MUL) && !mul_ph),
    .g11      (g11_q),
    .g12      (g12_q),
    .g22      (g22_q),
    .bx       (bx_q),
    .by       (by_q),
    .out_valid(d_valid),
    .dx       (dx),
    .dy       (dy)
  );

  // position is wide enough that no rounded offset can wrap back into range
  always_comb begin
    rnd_x = lk_rnd(sum_dx[D_W-1:FRAC-1]);
    rnd_y = lk_rnd(sum_dy[D_W-1:FRAC-1]);
    pos_x = PW'(x_q) + PW'(rnd_x);
    pos_y = PW'(y_q) + PW'(rnd_y);
    lost  = pos_x[PW-1] || (pos_x > PW'(COL - 2)) || pos_y[PW-1] || (pos_y > PW'(ROW - 2));
    conv  = (dx < EPS) && (dx > -EPS) && (dy < EPS) && (dy > -EPS);
  end

  assign b_x      = pos_x[COLBITS-1:0];
  assign b_y      = pos_y[ROWBITS-1:0];
  assign b_req    = (state_q == ST_REQ);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign status   = status_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    accept  = 1'b0;
    cap     = 1'b0;
    set_st  = 1'b0;
    st_val  = LK_CONV;
    case (state_q)
      ST_IDLE: if (start) begin
        accept = 1'b1;
        if (valid_det) state_n = ST_REQ;
        else begin
          state_n = ST_DONE;
          set_st  = 1'b1;
          st_val  = LK_SING;
        end
      end
      ST_REQ: if (b_valid) begin
        cap     = 1'b1;
        state_n = ST_MUL;
      end
      ST_MUL:  if (mul_ph) state_n = ST_ACC;
      ST_ACC:  state_n = ST_CHK;
      ST_CHK: begin
        state_n = ST_DONE;
        set_st  = 1'b1;
        if (conv)                           st_val = LK_CONV;
        else if (lost)                      st_val = LK_LOST;
        else if (iter_cnt == ITW'(MAX_ITER)) st_val = LK_MAXIT;
        else begin
          state_n = ST_REQ;
          set_st  = 1'b0;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      g11_q    <= '0;
      g12_q    <= '0;
      g22_q    <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      mul_ph   <= 1'b0;
      sum_dx   <= '0;
      sum_dy   <= '0;
      iter_cnt <= '0;
      status_q <= LK_CONV;
    end else begin
      mul_ph <= (state_q == ST_MUL) ? ~mul_ph : 1'b0;
      if (accept) begin
        x_q      <= x;
        y_q      <= y;
        g11_q    <= ginv_11;
        g12_q    <= ginv_12;
        g22_q    <= ginv_22;
        sum_dx   <= '0;
        sum_dy   <= '0;
        iter_cnt <= '0;
      end
      if (cap) begin
        bx_q <= bx;
        by_q <= by;
      end
      if ((state_q == ST_ACC) && d_valid) begin
        sum_dx   <= lk_sat(LK_WIDE_W'(sum_dx) + LK_WIDE_W'(dx));
        sum_dy   <= lk_sat(LK_WIDE_W'(sum_dy) + LK_WIDE_W'(dy));
        iter_cnt <= iter_cnt + ITW'(1);
      end
      if (set_st) status_q <= st_val;
    end
  end

endmodule

// File: tb/tb_lk_iter_ctrl.sv
// Directed bench for lk_iter_ctrl: expected positions and results queued at stimulus, checked on DUT output.
module tb_lk_iter_ctrl;
  import lk_pkg::*;

  logic              clk = 1'b0, reset = 1'b1, start = 1'b0, valid_det = 1'b0, b_valid = 1'b0;
  logic [5:0]        x = '0;
  logic [4:0]        y = '0;
  logic signed [63:0] ginv_11 = '0, ginv_12 = '0, ginv_22 = '0;
  logic signed [31:0] bx = '0, by = '0;
  logic              b_req, busy, done;
  logic [5:0]        b_x;
  logic [4:0]        b_y;
  logic [1:0]        status;
  logic [2:0]        iter_cnt;
  logic signed [39:0] sum_dx, sum_dy;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, req_cnt = 0, done_cnt = 0;
  int last_bv = 0, last_st = 0;

  typedef struct { logic [1:0] st; logic [2:0] it; logic [39:0] sx; logic [39:0] sy; } res_t;
  typedef struct { logic [5:0] px; logic [4:0] py; } pos_t;
  res_t exp_q[$];
  pos_t pos_q[$];

  localparam logic signed [63:0] G28 = 64'sh0000_0000_1000_0000;
  localparam logic signed [63:0] G29 = 64'sh0000_0000_2000_0000;

  lk_iter_ctrl #(.MAX_ITER(4)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
    .ginv_11(ginv_11), .ginv_12(ginv_12), .ginv_22(ginv_22), .valid_det(valid_det),
    .b_req(b_req), .b_x(b_x), .b_y(b_y), .b_valid(b_valid), .bx(bx), .by(by),
    .busy(busy), .done(done), .status(status), .iter_cnt(iter_cnt),
    .sum_dx(sum_dx), .sum_dy(sum_dy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b_req) req_cnt <= req_cnt + 1;
    if (done)  done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_pos(input int px, input int py);
    pos_q.push_back('{px: 6'(px), py: 5'(py)});
  endtask

  task automatic pop_pos_chk();
    pos_t e;
    if (pos_q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL pos_q: observed empty expected entry");
    end else begin
      e = pos_q.pop_front();
      chk("b_x", 64'(b_x), 64'(e.px));
      chk("b_y", 64'(b_y), 64'(e.py));
    end
  endtask

  task automatic start_feat(input int xv, input int yv, input logic signed [63:0] g11,
                            input logic signed [63:0] g12, input logic signed [63:0] g22,
                            input logic vd);
    x = 6'(xv); y = 5'(yv);
    ginv_11 = g11; ginv_12 = g12; ginv_22 = g22;
    valid_det = vd;
    start = 1'b1;
    last_st = cyc;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_b_req", 64'(b_req), 64'(vd));
  endtask

  task automatic serve(input logic signed [31:0] bxv, input logic signed [31:0] byv,
                       input int dly, input bit chk_lat, input bit stray);
    int n = 0;
    logic [5:0] hold_x;
    while (!b_req && n < 40) begin tick(); n++; end
    chk("req_seen", 64'(b_req), 64'd1);
    if (chk_lat) chk("req_latency", 64'(cyc - last_bv), 64'd5);
    hold_x = b_x;
    pop_pos_chk();
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("b_x_stable", 64'(b_x), 64'(hold_x));
    end
    bx = bxv; by = byv; b_valid = 1'b1;
    last_bv = cyc;
    tick();
    b_valid = 1'b0;
    bx = 32'sh1234_5678; by = -32'sh0765_4321;
    chk("b_req_drop", 64'(b_req), 64'd0);
    if (stray) begin
      start = 1'b1; valid_det = 1'b0; x = 6'd1; b_valid = 1'b1;
      tick();
      start = 1'b0; b_valid = 1'b0;
      chk("busy_in_mul", 64'(busy), 64'd1);
    end
  endtask

  task automatic finish_chk(input int ref_c, input int exp_lat);
    int n = 0;
    res_t e;
    while (!done && n < 40) begin tick(); n++; end
    chk("done_seen", 64'(done), 64'd1);
    chk("done_latency", 64'(cyc - ref_c), 64'(exp_lat));
    chk("busy_at_done", 64'(busy), 64'd1);
    chk("b_req_at_done", 64'(b_req), 64'd0);
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL exp_q: observed empty expected entry");
    end else begin
      e = exp_q.pop_front();
      chk("status", 64'(status), 64'(e.st));
      chk("iter_cnt", 64'(iter_cnt), 64'(e.it));
      chk("sum_dx", 64'(sum_dx), 64'(e.sx));
      chk("sum_dy", 64'(sum_dy), 64'(e.sy));
    end
    tick();
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int r0, d0, n;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_b_req", 64'(b_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_status", 64'(status), 64'(LK_CONV));
    chk("rst_iter", 64'(iter_cnt), 64'd0);
    chk("rst_sum_dx", 64'(sum_dx), 64'd0);
    chk("rst_sum_dy", 64'(sum_dy), 64'd0);
    chk("rst_b_x", 64'(b_x), 64'd0);
    chk("rst_b_y", 64'(b_y), 64'd0);
    tick();

    // 0.25 px per step, four steps: hits the iteration cap at exactly 1.0 px
    push_pos(5, 5); push_pos(5, 5); push_pos(6, 6); push_pos(6, 6);
    exp_q.push_back('{st: LK_MAXIT, it: 3'd4, sx: 40'h01_0000_0000, sy: 40'h01_0000_0000});
    start_feat(5, 5, G28, 64'sd0, G28, 1'b1);
    serve(32'sh4000_0000, 32'sh4000_0000, 0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) serve(32'sh4000_0000, 32'sh4000_0000, 0, 1'b1, 1'b0);
    finish_chk(last_bv, 5);

    push_pos(5, 5);
    exp_q.push_back('{st: LK_CONV, it: 3'd1, sx: 40'h00_0010_0000, sy: 40'h00_0010_0000});
    start_feat(5, 5, G28, 64'sd0, G28, 1'b1);
    serve(32'sh0010_0000, 32'sh0010_0000, 0, 1'b0, 1'b0);
    finish_chk(last_bv, 5);

    // just under one pixel rounds up to the out-of-range column COL-1
    r0 = req_cnt;
    push_pos(28, 5);
    exp_q.push_back('{st: LK_LOST, it: 3'd1, sx: 40'h00_FFFF_FFFE, sy: 40'h0});
    start_feat(28, 5, G29, 64'sd0, G29, 1'b1);
    serve(32'sh7FFF_FFFF, 32'sd0, 0, 1'b0, 1'b0);
    finish_chk(last_bv, 5);
    tick();
    chk("lost_req_cycles", 64'(req_cnt - r0), 64'd1);

    r0 = req_cnt;
    exp_q.push_back('{st: LK_SING, it: 3'd0, sx: 40'h0, sy: 40'h0});
    start_feat(10, 10, G28, 64'sd0, G28, 1'b0);
    finish_chk(last_st, 1);
    tick();
    chk("sing_req_cycles", 64'(req_cnt - r0), 64'd0);

    // abort while waiting on the second request
    push_pos(5, 5); push_pos(5, 5);
    start_feat(5, 5, G28, 64'sd0, G28, 1'b1);
    serve(32'sh4000_0000, 32'sh4000_0000, 0, 1'b0, 1'b0);
    n = 0;
    while (!b_req && n < 40) begin tick(); n++; end
    chk("abort_req_seen", 64'(b_req), 64'd1);
    pop_pos_chk();
    chk("abort_sum_pre", 64'(sum_dx), 64'h40_0000_00);
    tick(); tick();
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_b_req", 64'(b_req), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sum_dx", 64'(sum_dx), 64'd0);
    chk("abort_sum_dy", 64'(sum_dy), 64'd0);
    chk("abort_iter", 64'(iter_cnt), 64'd0);
    repeat (8) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // slow engine plus ignored start / b_valid during MUL: same answer as the first run
    push_pos(5, 5); push_pos(5, 5); push_pos(6, 6); push_pos(6, 6);
    exp_q.push_back('{st: LK_MAXIT, it: 3'd4, sx: 40'h01_0000_0000, sy: 40'h01_0000_0000});
    start_feat(5, 5, G28, 64'sd0, G28, 1'b1);
    for (int i = 0; i < 4; i++) serve(32'sh4000_0000, 32'sh4000_0000, 7, i > 0, 1'b1);
    finish_chk(last_bv, 5);

    chk("queues_drained", 64'(exp_q.size() + pos_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
